// File: rtl/cxu_router_pkg.sv
// Shared CXU types for the router: the error status code, the in-order tracking
// entry layout and the channel-count ceiling. Also provides the helper that
// sizes the performance-counter select port (used when CXU_ROUTER_PERF_EN is set).
package cxu_router_pkg;

  localparam int CXU_ROUTER_MAX_CHANNELS = 16;
  localparam int CXU_ORDER_CHAN_W        = 4;
  localparam int CXU_ORDER_ID_W          = 8;

  localparam logic [1:0] CXU_STATUS_ERR = 2'b11;

  typedef struct packed {
    logic [CXU_ORDER_CHAN_W-1:0] chan;
    logic                        err;
    logic [CXU_ORDER_ID_W-1:0]   id;
  } cxu_order_entry_t;

  function automatic int cxuSelWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cxu_router_order_fifo.sv
// cxu_order_fifo: small power-of-two FIFO remembering where each in-flight
// request went, so responses can be returned to the core in request order.
module cxu_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/cxu_router.sv
// cxu_router: fans the core's single CXU request stream out to NUM_CXU channels
// and returns responses strictly in request order. Requests to non-existent
// channels are answered locally with CXU_STATUS_ERR.
// Optional per-channel performance counters: define CXU_ROUTER_PERF_EN.
module cxu_router
  import cxu_router_pkg::*;
#(
  parameter int NUM_CXU         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REQ_ID_W        = 3,
  parameter int CXU_ID_W        = 4,
  parameter int STATE_ID_W      = 2,
  parameter int FUNC_ID_W       = 10,
  parameter int INSN_W          = 32,
  parameter int DATA_W          = 32,
  parameter int STATUS_W        = 2,
  localparam int PERF_SEL_W     = cxuSelWidth(NUM_CXU)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CXU_ROUTER_PERF_EN
  input  logic [PERF_SEL_W-1:0] perf_sel,
  input  logic                  perf_clear,
  output logic [31:0]           perf_req_count,
  output logic [31:0]           perf_stall_count,
`endif
  input  logic                  up_req_valid,
  output logic                  up_req_ready,
  input  logic [REQ_ID_W-1:0]   up_req_id,
  input  logic [CXU_ID_W-1:0]   up_req_cxu,
  input  logic [STATE_ID_W-1:0] up_req_state,
  input  logic [FUNC_ID_W-1:0]  up_req_func,
  input  logic [INSN_W-1:0]     up_req_insn,
  input  logic [DATA_W-1:0]     up_req_data0,
  input  logic [DATA_W-1:0]     up_req_data1,
  output logic                  up_resp_valid,
  input  logic                  up_resp_ready,
  output logic [REQ_ID_W-1:0]   up_resp_id,
  output logic [STATUS_W-1:0]   up_resp_status,
  output logic [DATA_W-1:0]     up_resp_data,
  output logic [NUM_CXU-1:0]    dn_req_valid,
  input  logic [NUM_CXU-1:0]    dn_req_ready,
  output logic [REQ_ID_W-1:0]   dn_req_id    [NUM_CXU],
  output logic [STATE_ID_W-1:0] dn_req_state [NUM_CXU],
  output logic [FUNC_ID_W-1:0]  dn_req_func  [NUM_CXU],
  output logic [INSN_W-1:0]     dn_req_insn  [NUM_CXU],
  output logic [DATA_W-1:0]     dn_req_data0 [NUM_CXU],
  output logic [DATA_W-1:0]     dn_req_data1 [NUM_CXU],
  input  logic [NUM_CXU-1:0]    dn_resp_valid,
  output logic [NUM_CXU-1:0]    dn_resp_ready,
  input  logic [REQ_ID_W-1:0]   dn_resp_id     [NUM_CXU],
  input  logic [STATUS_W-1:0]   dn_resp_status [NUM_CXU],
  input  logic [DATA_W-1:0]     dn_resp_data   [NUM_CXU]
);

  localparam int ENTRY_W = $bits(cxu_order_entry_t);

  logic [NUM_CXU-1:0]    reqValid_q;
  logic [REQ_ID_W-1:0]   reqId_q    [NUM_CXU];
  logic [STATE_ID_W-1:0] reqState_q [NUM_CXU];
  logic [FUNC_ID_W-1:0]  reqFunc_q  [NUM_CXU];
  logic [INSN_W-1:0]     reqInsn_q  [NUM_CXU];
  logic [DATA_W-1:0]     reqData0_q [NUM_CXU];
  logic [DATA_W-1:0]     reqData1_q [NUM_CXU];

  logic                       targetValid;
  logic                       targetFree;
  logic                       accept;
  logic                       respPop;
  logic                       respValid;
  logic                       fifoFull;
  logic                       fifoEmpty;
  logic [$clog2(MAX_OUTSTANDING):0] fifoCount;
  logic [ENTRY_W-1:0]         fifoRdata;
  cxu_order_entry_t           pushEntry;
  cxu_order_entry_t           head;

  assign targetValid = (int'(up_req_cxu) < NUM_CXU);

  // Can the addressed channel take a new request this cycle (empty or draining)?
  always_comb begin
    targetFree = 1'b0;
    for (int c = 0; c < NUM_CXU; c++) begin
      if (up_req_cxu == CXU_ID_W'(c)) targetFree = !reqValid_q[c] || dn_req_ready[c];
    end
  end

  // Ready never looks at the response side; rst gating keeps it low during reset.
  assign up_req_ready = rst && !fifoFull && (!targetValid || targetFree);
  assign accept       = up_req_valid && up_req_ready;

  assign pushEntry.chan = CXU_ORDER_CHAN_W'(up_req_cxu);
  assign pushEntry.err  = !targetValid;
  assign pushEntry.id   = CXU_ORDER_ID_W'(up_req_id);

  cxu_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ENTRY_W)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (respPop),
    .wdata_i (pushEntry),
    .rdata_o (fifoRdata),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Per-channel request registers: load on accept, hold until the channel takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqValid_q <= '0;
      for (int c = 0; c < NUM_CXU; c++) begin
        reqId_q[c]    <= '0;
        reqState_q[c] <= '0;
        reqFunc_q[c]  <= '0;
        reqInsn_q[c]  <= '0;
        reqData0_q[c] <= '0;
        reqData1_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CXU; c++) begin
        if (accept && (up_req_cxu == CXU_ID_W'(c))) begin
          reqValid_q[c] <= 1'b1;
          reqId_q[c]    <= up_req_id;
          reqState_q[c] <= up_req_state;
          reqFunc_q[c]  <= up_req_func;
          reqInsn_q[c]  <= up_req_insn;
          reqData0_q[c] <= up_req_data0;
          reqData1_q[c] <= up_req_data1;
        end else if (dn_req_ready[c]) begin
          reqValid_q[c] <= 1'b0;
        end
      end
    end
  end

  assign dn_req_valid = reqValid_q;
  assign dn_req_id    = reqId_q;
  assign dn_req_state = reqState_q;
  assign dn_req_func  = reqFunc_q;
  assign dn_req_insn  = reqInsn_q;
  assign dn_req_data0 = reqData0_q;
  assign dn_req_data1 = reqData1_q;

  assign head = cxu_order_entry_t'(fifoRdata);

  // Steer the response of the channel at the FIFO head (or a local error) to the core.
  always_comb begin
    respValid      = 1'b0;
    up_resp_id     = '0;
    up_resp_status = '0;
    up_resp_data   = '0;
    dn_resp_ready  = '0;
    if (!fifoEmpty) begin
      if (head.err) begin
        respValid      = 1'b1;
        up_resp_id     = REQ_ID_W'(head.id);
        up_resp_status = STATUS_W'(CXU_STATUS_ERR);
      end else begin
        for (int c = 0; c < NUM_CXU; c++) begin
          if (head.chan == CXU_ORDER_CHAN_W'(c)) begin
            respValid        = dn_resp_valid[c];
            up_resp_id       = dn_resp_id[c];
            up_resp_status   = dn_resp_status[c];
            up_resp_data     = dn_resp_data[c];
            dn_resp_ready[c] = up_resp_ready;
          end
        end
      end
    end
  end

  assign up_resp_valid = respValid;
  assign respPop       = respValid && up_resp_ready;

`ifdef CXU_ROUTER_PERF_EN
  logic [31:0] reqCount_q   [NUM_CXU];
  logic [31:0] stallCount_q [NUM_CXU];

  // Saturating per-channel counters; a clear overrides any same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CXU; c++) begin
        reqCount_q[c]   <= '0;
        stallCount_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CXU; c++) begin
        if (perf_clear) begin
          reqCount_q[c]   <= '0;
          stallCount_q[c] <= '0;
        end else begin
          if (accept && (up_req_cxu == CXU_ID_W'(c)) && (reqCount_q[c] != 32'hFFFF_FFFF))
            reqCount_q[c] <= reqCount_q[c] + 32'd1;
          if (reqValid_q[c] && !dn_req_ready[c] && (stallCount_q[c] != 32'hFFFF_FFFF))
            stallCount_q[c] <= stallCount_q[c] + 32'd1;
        end
      end
    end
  end

  // Expose the counters of the selected channel.
  always_comb begin
    perf_req_count   = '0;
    perf_stall_count = '0;
    for (int c = 0; c < NUM_CXU; c++) begin
      if (perf_sel == PERF_SEL_W'(c)) begin
        perf_req_count   = reqCount_q[c];
        perf_stall_count = stallCount_q[c];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cxu_router.sv
// Testbench for cxu_router with default parameters (NUM_CXU=4, MAX_OUTSTANDING=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
// The counter scenario is included when CXU_ROUTER_PERF_EN is defined.
module tb_cxu_router;

  logic        clk;
  logic        rst;
  logic        upReqValid;
  logic        upReqReady;
  logic [2:0]  upReqId;
  logic [3:0]  upReqCxu;
  logic [1:0]  upReqState;
  logic [9:0]  upReqFunc;
  logic [31:0] upReqInsn;
  logic [31:0] upReqData0;
  logic [31:0] upReqData1;
  logic        upRespValid;
  logic        upRespReady;
  logic [2:0]  upRespId;
  logic [1:0]  upRespStatus;
  logic [31:0] upRespData;
  logic [3:0]  dnReqValid;
  logic [3:0]  dnReqReady;
  logic [2:0]  dnReqId    [4];
  logic [1:0]  dnReqState [4];
  logic [9:0]  dnReqFunc  [4];
  logic [31:0] dnReqInsn  [4];
  logic [31:0] dnReqData0 [4];
  logic [31:0] dnReqData1 [4];
  logic [3:0]  dnRespValid;
  logic [3:0]  dnRespReady;
  logic [2:0]  dnRespId     [4];
  logic [1:0]  dnRespStatus [4];
  logic [31:0] dnRespData   [4];
`ifdef CXU_ROUTER_PERF_EN
  logic [1:0]  perfSel;
  logic        perfClear;
  logic [31:0] perfReqCount;
  logic [31:0] perfStallCount;
`endif

  int checks = 0;
  int errors = 0;

  cxu_router dut (
    .clk              (clk),
    .rst              (rst),
`ifdef CXU_ROUTER_PERF_EN
    .perf_sel         (perfSel),
    .perf_clear       (perfClear),
    .perf_req_count   (perfReqCount),
    .perf_stall_count (perfStallCount),
`endif
    .up_req_valid     (upReqValid),
    .up_req_ready     (upReqReady),
    .up_req_id        (upReqId),
    .up_req_cxu       (upReqCxu),
    .up_req_state     (upReqState),
    .up_req_func      (upReqFunc),
    .up_req_insn      (upReqInsn),
    .up_req_data0     (upReqData0),
    .up_req_data1     (upReqData1),
    .up_resp_valid    (upRespValid),
    .up_resp_ready    (upRespReady),
    .up_resp_id       (upRespId),
    .up_resp_status   (upRespStatus),
    .up_resp_data     (upRespData),
    .dn_req_valid     (dnReqValid),
    .dn_req_ready     (dnReqReady),
    .dn_req_id        (dnReqId),
    .dn_req_state     (dnReqState),
    .dn_req_func      (dnReqFunc),
    .dn_req_insn      (dnReqInsn),
    .dn_req_data0     (dnReqData0),
    .dn_req_data1     (dnReqData1),
    .dn_resp_valid    (dnRespValid),
    .dn_resp_ready    (dnRespReady),
    .dn_resp_id       (dnRespId),
    .dn_resp_status   (dnRespStatus),
    .dn_resp_data     (dnRespData)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one request on the falling edge and let the next rising edge take it.
  task automatic applyStimulus(input logic [3:0] cxu, input logic [2:0] id, input logic [31:0] d0);
    @(negedge clk);
    upReqValid = 1'b1;
    upReqCxu   = cxu;
    upReqId    = id;
    upReqData0 = d0;
    upReqData1 = ~d0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (upReqReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 0", upReqReady); end
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", upRespValid); end
    checks++; if (dnReqValid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dn_req_valid got %b want 0000", dnReqValid); end
    @(negedge clk);
    upReqValid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    dnReqReady  = 4'b0000;
    upRespReady = 1'b1;
    applyStimulus(4'd2, 3'd5, 32'h11);
    @(negedge clk);
    upReqId = 3'd6;
    #1;
    checks++; if (upReqReady !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_ready got %b want 0", upReqReady); end
    checks++; if (dnReqValid !== 4'b0100) begin errors++; $display("[TB] FAIL single_dn_valid got %b want 0100", dnReqValid); end
    checks++; if (dnReqData0[2] !== 32'h11) begin errors++; $display("[TB] FAIL single_dn_data0 got %h want 11", dnReqData0[2]); end
    checks++; if (dnReqId[2] !== 3'd5) begin errors++; $display("[TB] FAIL single_dn_id got %0d want 5", dnReqId[2]); end
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_resp got %b want 0", upRespValid); end
    upReqValid = 1'b0;
    dnReqReady = 4'b0100;
    @(negedge clk);
    checks++; if (dnReqValid !== 4'b0000) begin errors++; $display("[TB] FAIL single_dn_drop got %b want 0000", dnReqValid); end
    dnRespValid[2] = 1'b1; dnRespId[2] = 3'd5; dnRespData[2] = 32'h22; dnRespStatus[2] = 2'd0;
    #1;
    checks++; if (upRespValid !== 1'b1) begin errors++; $display("[TB] FAIL single_resp_valid got %b want 1", upRespValid); end
    checks++; if (upRespId !== 3'd5) begin errors++; $display("[TB] FAIL single_resp_id got %0d want 5", upRespId); end
    checks++; if (upRespData !== 32'h22) begin errors++; $display("[TB] FAIL single_resp_data got %h want 22", upRespData); end
    checks++; if (upRespStatus !== 2'd0) begin errors++; $display("[TB] FAIL single_resp_status got %0d want 0", upRespStatus); end
    checks++; if (dnRespReady !== 4'b0100) begin errors++; $display("[TB] FAIL single_dn_resp_ready got %b want 0100", dnRespReady); end
    @(negedge clk);
    dnRespValid = 4'b0000;
    #1;
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL single_empty got %b want 0", upRespValid); end
  endtask

  task automatic test_back_to_back();
    dnReqReady  = 4'b1111;
    upRespReady = 1'b1;
    applyStimulus(4'd1, 3'd1, 32'hB0);
    applyStimulus(4'd0, 3'd2, 32'hA0);
    @(negedge clk);
    upReqValid = 1'b0;
    dnRespValid[0] = 1'b1; dnRespId[0] = 3'd2; dnRespData[0] = 32'hA0; dnRespStatus[0] = 2'd0;
    #1;
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL order_wait got %b want 0", upRespValid); end
    checks++; if (dnRespReady !== 4'b0010) begin errors++; $display("[TB] FAIL order_head_ready got %b want 0010", dnRespReady); end
    @(negedge clk);
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL order_wait2 got %b want 0", upRespValid); end
    dnRespValid[1] = 1'b1; dnRespId[1] = 3'd1; dnRespData[1] = 32'hB1; dnRespStatus[1] = 2'd0;
    #1;
    checks++; if (upRespValid !== 1'b1 || upRespId !== 3'd1) begin errors++; $display("[TB] FAIL order_first got v=%b id=%0d want v=1 id=1", upRespValid, upRespId); end
    checks++; if (upRespData !== 32'hB1) begin errors++; $display("[TB] FAIL order_first_data got %h want b1", upRespData); end
    @(negedge clk);
    dnRespValid[1] = 1'b0;
    #1;
    checks++; if (upRespValid !== 1'b1 || upRespId !== 3'd2) begin errors++; $display("[TB] FAIL order_second got v=%b id=%0d want v=1 id=2", upRespValid, upRespId); end
    checks++; if (upRespData !== 32'hA0) begin errors++; $display("[TB] FAIL order_second_data got %h want a0", upRespData); end
    checks++; if (dnRespReady !== 4'b0001) begin errors++; $display("[TB] FAIL order_second_ready got %b want 0001", dnRespReady); end
    @(negedge clk);
    dnRespValid[0] = 1'b0;
    #1;
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL order_empty got %b want 0", upRespValid); end
  endtask

  task automatic test_invalid();
    upRespReady = 1'b0;
    @(negedge clk);
    upReqValid = 1'b1; upReqCxu = 4'd7; upReqId = 3'd3;
    #1;
    checks++; if (upReqReady !== 1'b1) begin errors++; $display("[TB] FAIL inv_ready got %b want 1", upReqReady); end
    @(negedge clk);
    upReqValid = 1'b0;
    #1;
    checks++; if (dnReqValid !== 4'b0000) begin errors++; $display("[TB] FAIL inv_no_dn got %b want 0000", dnReqValid); end
    checks++; if (upRespValid !== 1'b1 || upRespId !== 3'd3) begin errors++; $display("[TB] FAIL inv_resp got v=%b id=%0d want v=1 id=3", upRespValid, upRespId); end
    checks++; if (upRespStatus !== 2'b11) begin errors++; $display("[TB] FAIL inv_status got %b want 11", upRespStatus); end
    checks++; if (upRespData !== 32'h0) begin errors++; $display("[TB] FAIL inv_data got %h want 0", upRespData); end
    checks++; if (dnRespReady !== 4'b0000) begin errors++; $display("[TB] FAIL inv_dn_ready got %b want 0000", dnRespReady); end
    upRespReady = 1'b1;
    @(negedge clk);
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL inv_popped got %b want 0", upRespValid); end
  endtask

  task automatic test_full();
    upRespReady = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(4'd7, 3'(i), 32'h0);
    @(negedge clk);
    upReqId = 3'd4;
    #1;
    checks++; if (upReqReady !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b want 0", upReqReady); end
    checks++; if (upRespId !== 3'd0) begin errors++; $display("[TB] FAIL full_head got %0d want 0", upRespId); end
    upRespReady = 1'b1;
    #1;
    checks++; if (upReqReady !== 1'b0) begin errors++; $display("[TB] FAIL full_same_cycle got %b want 0", upReqReady); end
    @(negedge clk);
    upRespReady = 1'b0;
    #1;
    checks++; if (upReqReady !== 1'b1) begin errors++; $display("[TB] FAIL full_reopen got %b want 1", upReqReady); end
    checks++; if (upRespId !== 3'd1) begin errors++; $display("[TB] FAIL full_next_head got %0d want 1", upRespId); end
    @(negedge clk);
    upReqValid  = 1'b0;
    upRespReady = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      checks++; if (upRespValid !== 1'b1 || upRespId !== 3'(i)) begin errors++; $display("[TB] FAIL full_drain got v=%b id=%0d want v=1 id=%0d", upRespValid, upRespId, i); end
      @(negedge clk);
    end
    #1;
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL full_empty got %b want 0", upRespValid); end
  endtask

  task automatic test_reset_midflight();
    dnReqReady  = 4'b0000;
    upRespReady = 1'b0;
    applyStimulus(4'd0, 3'd1, 32'h1);
    applyStimulus(4'd1, 3'd2, 32'h2);
    applyStimulus(4'd2, 3'd3, 32'h3);
    @(negedge clk);
    upReqCxu = 4'd3;
    dnRespValid[0] = 1'b1; dnRespId[0] = 3'd1; dnRespData[0] = 32'h5; dnRespStatus[0] = 2'd0;
    #1;
    checks++; if (upRespValid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_resp got %b want 1", upRespValid); end
    rst = 1'b0;
    #1;
    checks++; if (dnReqValid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_dn_valid got %b want 0000", dnReqValid); end
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_resp_valid got %b want 0", upRespValid); end
    checks++; if (upReqReady !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_ready got %b want 0", upReqReady); end
    upReqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (upRespValid !== 1'b0 || dnRespReady !== 4'b0000) begin errors++; $display("[TB] FAIL mid_fifo_empty got v=%b r=%b want 0 0000", upRespValid, dnRespReady); end
    dnRespValid = 4'b0000;
    dnReqReady  = 4'b1111;
    upRespReady = 1'b1;
    applyStimulus(4'd3, 3'd6, 32'h33);
    @(negedge clk);
    upReqValid = 1'b0;
    #1;
    checks++; if (dnReqValid !== 4'b1000 || dnReqData0[3] !== 32'h33) begin errors++; $display("[TB] FAIL mid_new_req got v=%b d=%h want 1000 33", dnReqValid, dnReqData0[3]); end
    dnRespValid[3] = 1'b1; dnRespId[3] = 3'd6; dnRespData[3] = 32'h66; dnRespStatus[3] = 2'd1;
    #1;
    checks++; if (upRespValid !== 1'b1 || upRespId !== 3'd6 || upRespData !== 32'h66 || upRespStatus !== 2'd1) begin
      errors++; $display("[TB] FAIL mid_new_resp got v=%b id=%0d d=%h s=%0d want 1 6 66 1", upRespValid, upRespId, upRespData, upRespStatus);
    end
    @(negedge clk);
    dnRespValid = 4'b0000;
    #1;
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_done got %b want 0", upRespValid); end
  endtask

`ifdef CXU_ROUTER_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    dnReqReady  = 4'b1111;
    upRespReady = 1'b0;
    perfSel     = 2'd1;
    perfClear   = 1'b1;
    @(negedge clk);
    perfClear = 1'b0;
    applyStimulus(4'd1, 3'd0, 32'h0);
    applyStimulus(4'd1, 3'd1, 32'h1);
    applyStimulus(4'd1, 3'd2, 32'h2);
    @(negedge clk);
    upReqValid = 1'b0;
    dnReqReady = 4'b1101;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dnReqReady = 4'b1111;
    #1;
    checks++; if (perfReqCount !== 32'd3) begin errors++; $display("[TB] FAIL perf_req got %0d want 3", perfReqCount); end
    checks++; if (perfStallCount !== 32'd5) begin errors++; $display("[TB] FAIL perf_stall got %0d want 5", perfStallCount); end
    perfClear = 1'b1;
    @(negedge clk);
    perfClear = 1'b0;
    #1;
    checks++; if (perfReqCount !== 32'd0 || perfStallCount !== 32'd0) begin errors++; $display("[TB] FAIL perf_clear got %0d %0d want 0 0", perfReqCount, perfStallCount); end
    upRespReady = 1'b1;
    dnRespValid[1] = 1'b1; dnRespStatus[1] = 2'd0; dnRespData[1] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      dnRespId[1] = 3'(i);
      @(negedge clk);
    end
    dnRespValid = 4'b0000;
    #1;
    checks++; if (upRespValid !== 1'b0) begin errors++; $display("[TB] FAIL perf_drain got %b want 0", upRespValid); end
  endtask
`endif

  // Scenario sequence, then the summary.
  initial begin
    rst         = 1'b0;
    upReqValid  = 1'b1;
    upReqId     = 3'd0;
    upReqCxu    = 4'd1;
    upReqState  = 2'd1;
    upReqFunc   = 10'h2A;
    upReqInsn   = 32'hDEAD_BEEF;
    upReqData0  = 32'h0;
    upReqData1  = 32'h0;
    upRespReady = 1'b0;
    dnReqReady  = 4'b0000;
    dnRespValid = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      dnRespId[c]     = 3'd0;
      dnRespStatus[c] = 2'd0;
      dnRespData[c]   = 32'h0;
    end
`ifdef CXU_ROUTER_PERF_EN
    perfSel   = 2'd0;
    perfClear = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_full();
    test_reset_midflight();
`ifdef CXU_ROUTER_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
